// File: rtl/swo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swo_pkg
//  Description : Shared constants and the packer state type for the SWO
//                frame packer and its byte FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package swo_pkg;

  // Bytes per frame and the width needed to count 0..16 of them.
  localparam int FRAME_BYTES = 16;
  localparam int FRAME_LEN_W = 5;

  // Width of the idle counter and of the flush threshold.
  localparam int FLUSH_W = 17;

  // Packer state: collecting bytes, or holding a finished frame.
  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } pack_state_e;

endpackage : swo_pkg
`default_nettype wire

// File: rtl/swo_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : swo_byte_fifo
//  Description : Byte-wide circular-buffer FIFO, 2**DEPTH_LOG2 entries.
//                Pointers carry an extra wrap bit so that full and empty are
//                distinguished without a separate occupancy counter. The read
//                data is the head entry, presented combinationally.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                i_wr, i_wdata  - write request and byte (ignored when full)
//                i_rd, o_rdata  - pop request (ignored when empty), head byte
//                o_empty, o_full- occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module swo_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  input  logic       i_rd,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic                w_do_wr;
  logic                w_do_rd;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);

  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;

  assign o_rdata = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + (DEPTH_LOG2 + 1)'(1);
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

endmodule : swo_byte_fifo
`default_nettype wire

// File: rtl/swo_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : swo_frame_packer
//  Description : Turns the SWO decoder's toggling byte-ready into byte writes,
//                buffers them, and packs them into 16-byte frames offered on a
//                valid/ready handshake. A partial frame is offered once no new
//                byte has arrived for FLUSH_TICKS cycles.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                i_byte_tog          - level change = one new byte
//                i_byte_in[7:0]      - byte accompanying the toggle
//                o_frame_data[127:0] - byte k at bits [8k+7:8k]
//                o_frame_len[4:0]    - valid bytes, 0 when no frame offered
//                o_frame_valid       - frame offered
//                i_frame_ready       - consumer accepts the offered frame
//                o_overflow_count    - saturating count of dropped bytes
//  Revision    : 1.0 - initial release
// ============================================================================
module swo_frame_packer
  import swo_pkg::*;
#(
  parameter int                 DEPTH_LOG2  = 4,
  parameter logic [FLUSH_W-1:0] FLUSH_TICKS = 17'd65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_byte_tog,
  input  logic [7:0]               i_byte_in,
  output logic [FRAME_BYTES*8-1:0] o_frame_data,
  output logic [FRAME_LEN_W-1:0]   o_frame_len,
  output logic                     o_frame_valid,
  input  logic                     i_frame_ready,
  output logic [15:0]              o_overflow_count
);

  logic                     r_tog_q;
  logic                     w_strobe;
  logic                     w_wr;
  logic                     w_pop;
  logic                     w_empty;
  logic                     w_full;
  logic [7:0]               w_rdata;

  pack_state_e              r_state;
  logic [FRAME_LEN_W-1:0]   r_len;
  logic [FRAME_BYTES*8-1:0] r_frame_data;
  logic [FLUSH_W-1:0]       r_idle;
  logic                     r_valid;
  logic [15:0]              r_ovf;

  // ---------------------------------------------------------------------------
  // Toggle detect: decoder shares this clock, so no synchroniser is needed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tog_q <= 1'b0;
    end else begin
      r_tog_q <= i_byte_tog;
    end
  end

  assign w_strobe = i_byte_tog ^ r_tog_q;

  // Fullness is the pre-edge flag, so a same-cycle pop never frees a slot.
  assign w_wr  = w_strobe && !w_full;
  assign w_pop = (r_state == FILL) && !w_empty;

  swo_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (i_byte_in),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // ---------------------------------------------------------------------------
  // Dropped-byte counter, saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (w_strobe && w_full && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packer FSM with idle counter and frame register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_len        <= '0;
      r_frame_data <= '0;
      r_idle       <= '0;
      r_valid      <= 1'b0;
    end else if (r_state == FILL) begin
      if (w_pop) begin
        r_frame_data[{r_len[3:0], 3'b000} +: 8] <= w_rdata;
        r_len  <= r_len + FRAME_LEN_W'(1);
        r_idle <= '0;
        if (r_len == FRAME_LEN_W'(FRAME_BYTES - 1)) begin
          r_state <= PRESENT;
          r_valid <= 1'b1;
        end
      end else if (r_len != '0) begin
        // FIFO empty with a partial frame pending: count toward the flush.
        if (r_idle == FLUSH_TICKS) begin
          r_state <= PRESENT;
          r_valid <= 1'b1;
          r_idle  <= '0;
        end else begin
          r_idle <= r_idle + FLUSH_W'(1);
        end
      end
    end else begin
      r_idle <= '0;
      if (i_frame_ready) begin
        r_state      <= FILL;
        r_valid      <= 1'b0;
        r_len        <= '0;
        r_frame_data <= '0;
      end
    end
  end

  assign o_frame_valid    = r_valid;
  assign o_frame_data     = r_frame_data;
  assign o_frame_len      = r_valid ? r_len : '0;
  assign o_overflow_count = r_ovf;

endmodule : swo_frame_packer
`default_nettype wire

// File: tb/tb_swo_frame_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_swo_frame_packer
//  Description : Self-checking bench for swo_frame_packer. A queue-based
//                reference model tracks the expected frame outputs every
//                cycle; directed phases add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swo_frame_packer;

  localparam int DEPTH = 16;
  localparam int FLUSH = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         byte_tog;
  logic [7:0]   byte_in;
  logic         frame_ready;
  logic [127:0] frame_data;
  logic [4:0]   frame_len;
  logic         frame_valid;
  logic [15:0]  overflow_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_print  = 0;
  int cyc      = 0;

  swo_frame_packer #(
    .DEPTH_LOG2  (4),
    .FLUSH_TICKS (17'd100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_byte_tog       (byte_tog),
    .i_byte_in        (byte_in),
    .o_frame_data     (frame_data),
    .o_frame_len      (frame_len),
    .o_frame_valid    (frame_valid),
    .i_frame_ready    (frame_ready),
    .o_overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: FIFO as a queue, frame as a byte array.
  // --------------------------------------------------------------------------
  logic [7:0] q[$];
  logic [7:0] m_frame[16];
  int         m_len;
  bit         m_present;
  int         m_idle;
  int         m_ovf;
  bit         m_tog;

  always @(posedge clk or posedge rst) begin : model
    int pre;
    bit strobe;
    if (rst) begin
      q.delete();
      foreach (m_frame[k]) m_frame[k] = 8'h00;
      m_len = 0; m_present = 0; m_idle = 0; m_ovf = 0; m_tog = 0;
    end else begin
      strobe = (byte_tog != m_tog);
      m_tog  = byte_tog;
      pre    = q.size();
      if (m_present) begin
        m_idle = 0;
        if (frame_ready) begin
          m_present = 0;
          m_len = 0;
          foreach (m_frame[k]) m_frame[k] = 8'h00;
        end
      end else if (pre > 0) begin
        m_frame[m_len] = q.pop_front();
        m_len++;
        m_idle = 0;
        if (m_len == 16) m_present = 1;
      end else if (m_len > 0) begin
        if (m_idle >= FLUSH) begin
          m_present = 1;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      if (strobe) begin
        if (pre >= DEPTH) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          q.push_back(byte_in);
        end
      end
    end
  end

  function automatic logic [127:0] model_data();
    logic [127:0] d = '0;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = m_frame[k];
    return d;
  endfunction

  // Per-cycle comparison against the model, sampled 2 ns after the edge.
  always begin
    @(posedge clk);
    #2;
    chk("valid", {127'd0, frame_valid}, {127'd0, m_present});
    chk("len", {123'd0, frame_len}, m_present ? 128'(m_len) : 128'd0);
    chk("overflow", {112'd0, overflow_count}, 128'(m_ovf));
    if (m_present) chk("data", frame_data, model_data());
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_in  = b;
    byte_tog = ~byte_tog;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #2;
      if (frame_valid) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) chk("wait_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic accept();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  function automatic logic [127:0] ramp(input int base, input int n);
    logic [127:0] d = '0;
    for (int k = 0; k < n; k++) d[8*k +: 8] = 8'(base + k);
    return d;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int k;
    rst = 1'b1; byte_tog = 1'b0; byte_in = 8'h00; frame_ready = 1'b0;
    idle(3);
    chk("rst_valid", {127'd0, frame_valid}, 128'd0);
    chk("rst_len", {123'd0, frame_len}, 128'd0);
    chk("rst_data", frame_data, 128'd0);
    chk("rst_ovf", {112'd0, overflow_count}, 128'd0);
    @(negedge clk); rst = 1'b0;
    idle(3);

    // Full frame, 0x00..0x0F at one byte per 20 cycles.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 20);
    wait_valid(50, t);
    chk("t1_data", frame_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_len", {123'd0, frame_len}, 128'd16);
    idle(30);
    chk("t1_hold_valid", {127'd0, frame_valid}, 128'd1);
    accept();
    idle(3);
    chk("t1_after_accept", {127'd0, frame_valid}, 128'd0);

    // Flush after 3 bytes: valid appears 101 cycles after the third pop.
    send_byte(8'hA1, 20);
    send_byte(8'hB2, 20);
    @(negedge clk);
    byte_in = 8'hC3; byte_tog = ~byte_tog;
    k = cyc;
    wait_valid(300, t);
    chk("t2_flush_cycle", 128'(t), 128'(k + 103));
    chk("t2_len", {123'd0, frame_len}, 128'd3);
    chk("t2_data", frame_data, 128'h00000000000000000000000000C3B2A1);
    accept();

    // Five toggles on consecutive cycles.
    idle(5);
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1);
    wait_valid(300, t);
    chk("t4_len", {123'd0, frame_len}, 128'd5);
    chk("t4_data", frame_data, 128'h00000000000000000000005453525150);
    chk("t4_ovf", {112'd0, overflow_count}, 128'd0);
    accept();

    // Reset mid-frame after 7 bytes.
    idle(5);
    for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i), 3);
    @(negedge clk);
    rst = 1'b1; byte_tog = 1'b0;
    #1;
    chk("t5_rst_valid", {127'd0, frame_valid}, 128'd0);
    chk("t5_rst_len", {123'd0, frame_len}, 128'd0);
    chk("t5_rst_data", frame_data, 128'd0);
    chk("t5_rst_ovf", {112'd0, overflow_count}, 128'd0);
    @(negedge clk); rst = 1'b0;
    idle(2);
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 4);
    wait_valid(50, t);
    chk("t5_data", frame_data, ramp(8'h80, 16));
    chk("t5_len", {123'd0, frame_len}, 128'd16);
    accept();

    // Consumer stalled, 40 bytes: 16 framed, 16 buffered, 8 dropped.
    idle(5);
    for (int i = 0; i < 40; i++) send_byte(8'(i), 2);
    idle(5);
    chk("t3_ovf", {112'd0, overflow_count}, 128'd8);
    chk("t3_data1", frame_data, 128'h0F0E0D0C0B0A09080706050403020100);
    accept();
    wait_valid(50, t);
    chk("t3_data2", frame_data, 128'h1F1E1D1C1B1A19181716151413121110);
    chk("t3_len2", {123'd0, frame_len}, 128'd16);
    accept();

    // Randomised traffic and consumer back-pressure.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      frame_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        byte_in  = 8'($urandom);
        byte_tog = ~byte_tog;
      end
    end
    @(negedge clk); frame_ready = 1'b1;
    idle(400);
    chk("rand_drained", {127'd0, frame_valid}, 128'd0);

    // Saturate the overflow counter.
    @(negedge clk); rst = 1'b1; byte_tog = 1'b0; frame_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'(i), 2);
    idle(3);
    for (int i = 0; i < 70000; i++) send_byte(8'hEE, 1);
    idle(3);
    chk("sat_ovf", {112'd0, overflow_count}, 128'h0000FFFF);
    accept();
    idle(40);
    chk("sat_hold", {112'd0, overflow_count}, 128'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_swo_frame_packer
`default_nettype wire

// File: doc/swo_frame_packer.md
# swo_frame_packer

Downstream stage of the Manchester SWO decoder. Converts the decoder's toggling byte-ready indicator into single-cycle byte writes and buffers them in a small FIFO. Packs bytes into 16-byte frames and presents each frame on a valid/ready handshake to the USB/packet transmit layer. Partial frames are flushed after an idle timeout, so low-rate SWO traffic is not held back.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes.
- FLUSH_TICKS, 17'd65535: idle clk cycles before a partial frame is flushed; 17 bits, must be ≥1.
- clk  in  1  module clock, same clock as the upstream SWO decoder.
- rst  in  1  asynchronous, active-high reset.
- byte_tog  in  1  toggling byte-ready from the decoder; each level change means one new byte.
- byte_in  in  8  byte from the decoder, stable from the toggle until the next toggle.
- frame_data  out  128  byte k at bits [8k+7:8k]; unfilled bytes are 0.
- frame_len  out  5  valid bytes in frame_data, 1..16; 0 when frame_valid=0.
- frame_valid  out  1  frame presented.
- frame_ready  in  1  consumer accepts the frame when it is high together with frame_valid.
- overflow_count  out  16  bytes dropped because the FIFO was full; saturates at 16'hFFFF.

## Operation
- Toggle detect: tog_q registers byte_tog and resets to 0. strobe = byte_tog ^ tog_q. The upstream toggle must reset to 0. No synchroniser, because both blocks run on one clock.
- FIFO: on strobe, byte_in is written if count < depth. If the FIFO is full, the byte is dropped and overflow_count increments, saturating. Fullness is judged on the pre-edge count, so a simultaneous pop does not make room for a write.
- Packer FSM, 2 states:
  - FILL: pops one byte per cycle when the FIFO is non-empty and stores it at slot frame_len_int.
    - Goes to PRESENT when the 16th byte is stored.
    - Also goes to PRESENT when frame_len_int>0 and idle_cnt reaches FLUSH_TICKS.
  - PRESENT: frame_valid=1, and frame_data and frame_len are held stable.
    - No pops happen in this state.
    - On frame_ready, returns to FILL, clears frame_len_int to 0, and zeroes frame_data.
- idle_cnt (17 bits):
  - Clears to 0 on every pop and in PRESENT.
  - Increments in FILL while the FIFO is empty and frame_len_int>0.
  - Holds at 0 while frame_len_int=0.
- The FIFO keeps accepting writes during PRESENT.
- Reset values: frame_valid=0, frame_len=0, frame_data=0, overflow_count=0, state=FILL, FIFO empty, idle_cnt=0, tog_q=0.
- Reset mid-operation discards FIFO contents and any partial or presented frame.

## Timing
- Toggle at edge N → strobe in cycle N..N+1 → byte written at edge N+1 → popped into the frame at edge N+2 (FIFO non-empty, state FILL).
- 16th byte popped at edge E → frame_valid=1 from E.
- Flush: last pop at edge P, then no further bytes → idle_cnt=FLUSH_TICKS at edge P+FLUSH_TICKS → frame_valid=1 after edge P+FLUSH_TICKS+1.
- Handshake:
  - frame_valid=1 and frame_ready=1 at edge A → frame_valid=0 after A, and the first pop of the next frame can occur at A+1.
  - frame_ready while frame_valid=0 is ignored.
  - frame_valid does not drop without acceptance.
- Sustained throughput is 16 bytes per 17 cycles plus the handshake wait. The decoder delivers at most 1 byte per ~16 cycles, so the FIFO absorbs consumer stalls only.
- Toggles on consecutive cycles are each counted as a byte.

## Structure
- Package swo_pkg:
  - FRAME_BYTES=16 and FRAME_LEN_W=5.
  - Packer state encoding FILL=1'b0 and PRESENT=1'b1.
  - FLUSH_W=17.
- Sub-module swo_byte_fifo (parameter DEPTH_LOG2; ports clk, rst, wr, wdata, rd, rdata, empty, full):
  - Circular buffer with registered pointers and an extra wrap bit.
  - The read data path is combinational from the head entry.
- The top level holds the toggle detect, overflow counter, packer FSM, idle counter, and frame register.

## Test plan
- Reset, then 16 toggles carrying 0x00..0x0F at 1 per 20 cycles → one frame, frame_len=16, frame_data=128'h0F0E…0100, frame_valid stays until frame_ready.
- FLUSH_TICKS=100, 3 bytes 0xA1, 0xB2, 0xC3 then silence → frame_valid exactly 101 cycles after the third pop, frame_len=3, frame_data=128'h…00C3B2A1.
- frame_ready held low, 40 bytes sent (DEPTH_LOG2=4) → first frame bytes 0..15, FIFO holds 16..31, overflow_count=8; after ready, the second frame equals bytes 16..31.
- Toggles on consecutive cycles, 5 bytes → FIFO count 5, all 5 appear in order, overflow_count=0.
- Assert rst mid-frame after 7 bytes → all outputs 0 immediately; the next 16 bytes form a clean frame starting at the first post-reset byte.
- overflow_count preloaded near saturation by forcing 70000 drops → reads 16'hFFFF and does not wrap.
